// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if
// Data-memory request/acknowledge bus between the MEM-stage controller
// (master) and the data memory (slave).
//   dmem_req   master->slave  access request, held until ack or abort
//   dmem_we    master->slave  1 = store, 0 = load
//   dmem_addr  master->slave  doubleword-aligned address
//   dmem_wdata master->slave  store data already shifted onto its byte lanes
//   dmem_be    master->slave  byte enables, one per byte of the doubleword
//   dmem_rdata slave->master  full doubleword read data
//   dmem_ack   slave->master  access complete this cycle
interface mem_stage_ctrl_if #(
    parameter int XLEN = 64
);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [7:0]      dmem_be;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// MEM-stage controller sitting behind the EX/MEM pipeline register.
// Resolves the branch, performs loads/stores over the dmem interface with
// byte lanes and sign/zero extension, drives the MEM/WB register and stalls
// the front of the pipeline while an access is outstanding.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   *_store               EX/MEM register fields (controls, flags, data, rd)
//   dmem                  memory bus (master side)
//   pc_src, branch_target branch decision and target
//   stall                 freeze IF/ID/EX and EX/MEM
//   mem_timeout           sticky: memory never acknowledged
//   misaligned            access suppressed because of bad alignment
//   *_wb                  MEM/WB register outputs
module mem_stage_ctrl #(
    parameter int XLEN     = 64,
    parameter int MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWrite_store,
    input  logic            MemtoReg_store,
    input  logic            Branch_store,
    input  logic            Zero_store,
    input  logic            is_greater_store,
    input  logic            MemWrite_store,
    input  logic            MemRead_store,
    input  logic [XLEN-1:0] PCplusimm_store,
    input  logic [XLEN-1:0] ALU_result_store,
    input  logic [XLEN-1:0] WriteData_store,
    input  logic [3:0]      funct_in_store,
    input  logic [4:0]      rd_store,
    mem_stage_ctrl_if.master dmem,
    output logic            pc_src,
    output logic [XLEN-1:0] branch_target,
    output logic            stall,
    output logic            mem_timeout,
    output logic            misaligned,
    output logic            RegWrite_wb,
    output logic            MemtoReg_wb,
    output logic [XLEN-1:0] ReadData_wb,
    output logic [XLEN-1:0] ALU_result_wb,
    output logic [4:0]      rd_wb
);
    localparam int TW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT_RELEASE} state_t;

    state_t state, next_state;

    logic [2:0]      funct3;
    logic [2:0]      offset;
    logic            mem_op;
    logic            aligned;
    logic            branch_cond;
    logic [7:0]      size_mask;
    logic [7:0]      be_calc;
    logic [XLEN-1:0] wdata_calc;

    // funct7[5] only selects ALU variants, which were resolved back in EX
    logic unused_funct7;
    assign unused_funct7 = funct_in_store[3];

    // Request attributes latched at issue so the bus stays stable in ACCESS
    logic [XLEN-1:0] lat_alu;
    logic [XLEN-1:0] lat_wdata;
    logic [7:0]      lat_be;
    logic [1:0]      lat_size;
    logic            lat_unsigned;
    logic            lat_we;
    logic            lat_rw;
    logic            lat_mtr;
    logic [4:0]      lat_rd;
    logic [TW-1:0]   timer;

    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] load_ext;

    logic            req_c, we_c;
    logic [XLEN-1:0] addr_c, wdata_c;
    logic [7:0]      be_c;
    logic            issue, cap_pass, cap_ack, cap_abort, timeout_hit;

    assign funct3        = funct_in_store[2:0];
    assign offset        = ALU_result_store[2:0];
    assign mem_op        = MemRead_store | MemWrite_store;
    assign branch_target = PCplusimm_store;
    assign pc_src        = Branch_store & branch_cond;
    assign be_calc       = size_mask << offset;
    assign wdata_calc    = WriteData_store << {offset, 3'b000};

    // Branch condition chosen by funct3 (beq, bne, blt-style, bge-style)
    always_comb begin
        branch_cond = 1'b0;
        case (funct3)
            3'b000:  branch_cond = Zero_store;
            3'b001:  branch_cond = ~Zero_store;
            3'b100:  branch_cond = ~Zero_store & ~is_greater_store;
            3'b101:  branch_cond = Zero_store | is_greater_store;
            default: branch_cond = 1'b0;
        endcase
    end

    // Access size gives both the lane mask and the alignment rule
    always_comb begin
        size_mask = 8'h00;
        aligned   = 1'b0;
        case (funct3[1:0])
            2'b00:   begin size_mask = 8'h01; aligned = 1'b1;                end
            2'b01:   begin size_mask = 8'h03; aligned = ~offset[0];          end
            2'b10:   begin size_mask = 8'h0F; aligned = (offset[1:0] == 2'b00); end
            default: begin size_mask = 8'hFF; aligned = (offset == 3'b000);  end
        endcase
    end

    // Pick the addressed lane from the returned doubleword and extend it
    always_comb begin
        lane     = dmem.dmem_rdata >> {lat_alu[2:0], 3'b000};
        load_ext = lane;
        case (lat_size)
            2'b00:   load_ext = {{(XLEN-8){~lat_unsigned & lane[7]}}, lane[7:0]};
            2'b01:   load_ext = {{(XLEN-16){~lat_unsigned & lane[15]}}, lane[15:0]};
            2'b10:   load_ext = {{(XLEN-32){~lat_unsigned & lane[31]}}, lane[31:0]};
            default: load_ext = lane;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next state and bus/stall outputs. The IDLE request path is gated by
    // reset so the bus and stall drop the moment reset rises.
    always_comb begin
        next_state  = state;
        req_c       = 1'b0;
        we_c        = 1'b0;
        addr_c      = '0;
        be_c        = 8'h00;
        wdata_c     = '0;
        stall       = 1'b0;
        misaligned  = 1'b0;
        issue       = 1'b0;
        cap_pass    = 1'b0;
        cap_ack     = 1'b0;
        cap_abort   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (!reset) begin
                    if (mem_op && aligned) begin
                        issue      = 1'b1;
                        req_c      = 1'b1;
                        we_c       = MemWrite_store;
                        addr_c     = {ALU_result_store[XLEN-1:3], 3'b000};
                        be_c       = be_calc;
                        wdata_c    = wdata_calc;
                        stall      = 1'b1;
                        next_state = ACCESS;
                    end else begin
                        cap_pass   = 1'b1;
                        misaligned = mem_op;
                    end
                end
            end
            ACCESS: begin
                req_c   = 1'b1;
                we_c    = lat_we;
                addr_c  = {lat_alu[XLEN-1:3], 3'b000};
                be_c    = lat_be;
                wdata_c = lat_wdata;
                stall   = 1'b1;
                if (dmem.dmem_ack) begin
                    cap_ack    = 1'b1;
                    next_state = WAIT_RELEASE;
                end else if (timer == TW'(MAX_WAIT - 1)) begin
                    cap_abort   = 1'b1;
                    timeout_hit = 1'b1;
                    next_state  = WAIT_RELEASE;
                end
            end
            // One idle cycle lets EX/MEM advance so the finished op is not reissued
            WAIT_RELEASE: next_state = IDLE;
            default:      next_state = IDLE;
        endcase
    end

    assign dmem.dmem_req   = req_c;
    assign dmem.dmem_we    = we_c;
    assign dmem.dmem_addr  = addr_c;
    assign dmem.dmem_be    = be_c;
    assign dmem.dmem_wdata = wdata_c;

    // Request latch, wait timer, sticky timeout and the MEM/WB register.
    // MEM/WB only moves on a capture event, so it holds while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_alu       <= '0;
            lat_wdata     <= '0;
            lat_be        <= 8'h00;
            lat_size      <= 2'b00;
            lat_unsigned  <= 1'b0;
            lat_we        <= 1'b0;
            lat_rw        <= 1'b0;
            lat_mtr       <= 1'b0;
            lat_rd        <= 5'd0;
            timer         <= '0;
            mem_timeout   <= 1'b0;
            RegWrite_wb   <= 1'b0;
            MemtoReg_wb   <= 1'b0;
            ReadData_wb   <= '0;
            ALU_result_wb <= '0;
            rd_wb         <= 5'd0;
        end else begin
            if (issue) begin
                lat_alu      <= ALU_result_store;
                lat_wdata    <= wdata_calc;
                lat_be       <= be_calc;
                lat_size     <= funct3[1:0];
                lat_unsigned <= funct3[2];
                lat_we       <= MemWrite_store;
                lat_rw       <= RegWrite_store;
                lat_mtr      <= MemtoReg_store;
                lat_rd       <= rd_store;
            end
            if (state == ACCESS && next_state == ACCESS) timer <= timer + TW'(1);
            else                                         timer <= '0;
            if (timeout_hit) mem_timeout <= 1'b1;
            if (cap_pass) begin
                RegWrite_wb   <= RegWrite_store & ~mem_op;
                MemtoReg_wb   <= MemtoReg_store;
                ReadData_wb   <= '0;
                ALU_result_wb <= ALU_result_store;
                rd_wb         <= rd_store;
            end else if (cap_ack || cap_abort) begin
                RegWrite_wb   <= cap_ack & lat_rw;
                MemtoReg_wb   <= lat_mtr;
                ReadData_wb   <= (cap_ack && !lat_we) ? load_ext : '0;
                ALU_result_wb <= lat_alu;
                rd_wb         <= lat_rd;
            end
        end
    end
endmodule
